// File: rtl/vid_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vid_mem_arbiter
// Description : Shares one 32-bit SDRAM command port between the video
//               scan-out prefetch path and the CPU data port. Keeps a small
//               prefetch FIFO of framebuffer words, walks the framebuffer
//               linearly and restarts the walk on every frame pulse.
//               Optional underrun statistics counter is enabled by defining
//               the macro VID_MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_mem_arbiter #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned FB_BASE    = 0,
  parameter int unsigned FB_WORDS   = 153600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOW_WATER  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_frame,
  input  logic              vid_req,
  output logic [31:0]       vid_data,
  output logic              vid_underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef VID_MEM_ARB_STATS_EN
  ,
  output logic [15:0]       vid_underrun_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(FB_WORDS + 1);

  localparam logic [LVL_W-1:0]  C_DEPTH    = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  C_LOW      = LVL_W'(LOW_WATER);
  localparam logic [CNT_W-1:0]  C_FB_WORDS = CNT_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0] C_FB_BASE  = ADDR_W'(FB_BASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Transaction FSM and command registers
  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic               txn_vid_q, txn_vid_d;     // current transaction is a video fetch
  logic               drop_q, drop_d;           // discard the in-flight video word
  logic               last_vid_q, last_vid_d;   // last grant went to video

  // Prefetch FIFO and framebuffer walker
  logic [31:0]        fifo_q [FIFO_DEPTH];
  logic [31:0]        fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [31:0]        last_word_q, last_word_d;  // word shown while the FIFO is empty
  logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic               underrun_q, underrun_d;

  logic               fifo_empty;
  logic               vid_elig;
  logic               grant_vid;
  logic               do_push;
  logic               do_pop;
  logic               underrun_req;

  assign fifo_empty   = (level_q == '0);
  assign vid_elig     = (level_q < C_DEPTH) && (fetch_cnt_q < C_FB_WORDS) && !vid_frame;
  // Below the low-water mark video wins outright; otherwise ties alternate.
  assign grant_vid    = vid_elig && ((level_q < C_LOW) || !cpu_req || !last_vid_q);
  assign do_pop       = vid_req && !vid_frame && !fifo_empty;
  assign underrun_req = vid_req && !vid_frame && fifo_empty;
  assign do_push      = (state_q == S_RD) && mem_rvalid && txn_vid_q && !drop_q && !vid_frame;

  // Next-state and command-register logic for the single outstanding transaction
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    txn_vid_d   = txn_vid_q;
    drop_d      = drop_q;
    last_vid_d  = last_vid_q;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (grant_vid) begin
          state_d     = S_CMD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = C_FB_BASE + ADDR_W'(fetch_cnt_q);
          mem_wdata_d = '0;
          mem_wstrb_d = 4'hF;
          txn_vid_d   = 1'b1;
          last_vid_d  = 1'b1;
        end else if (cpu_req) begin
          state_d     = S_CMD;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_wstrb_d = cpu_wstrb;
          txn_vid_d   = 1'b0;
          last_vid_d  = 1'b0;
        end
      end
      S_CMD: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            // Only the CPU writes; its ack is high during DONE.
            state_d   = S_DONE;
            cpu_ack_d = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          if (!txn_vid_q) begin
            cpu_rdata_d = mem_rdata;
            cpu_ack_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A frame restart while a transaction is open poisons any video data it returns.
    if (state_q != S_IDLE && vid_frame) begin
      drop_d = 1'b1;
    end
  end

  // FIFO, framebuffer walker and underrun flag; a frame pulse overrides all of them
  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    last_word_d = last_word_q;
    fetch_cnt_d = fetch_cnt_q;
    underrun_d  = underrun_q;

    if (do_push) begin
      fifo_d[wr_ptr_q] = mem_rdata;
    end

    if (vid_frame) begin
      wr_ptr_d    = rd_ptr_q;
      level_d     = '0;
      fetch_cnt_d = '0;
      underrun_d  = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        last_word_d = fifo_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (state_q == S_CMD && mem_ready && txn_vid_q && !drop_q) begin
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
      if (underrun_req) begin
        underrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      txn_vid_q   <= 1'b0;
      drop_q      <= 1'b0;
      last_vid_q  <= 1'b0;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      last_word_q <= '0;
      fetch_cnt_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      txn_vid_q   <= txn_vid_d;
      drop_q      <= drop_d;
      last_vid_q  <= last_vid_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      last_word_q <= last_word_d;
      fetch_cnt_q <= fetch_cnt_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef VID_MEM_ARB_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of underrun requests, restarted by each frame pulse
  always_comb begin
    ucnt_d = ucnt_q;
    if (vid_frame) begin
      ucnt_d = '0;
    end else if (underrun_req && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Underrun counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign vid_underrun_cnt = ucnt_q;
`endif

  assign vid_data     = fifo_empty ? last_word_q : fifo_q[rd_ptr_q];
  assign vid_underrun = underrun_q;
  assign cpu_ack      = cpu_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_vid_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_mem_arbiter
// Description : Randomized self-checking bench for vid_mem_arbiter. Acts as
//               the SDRAM controller, CPU and video controller, and compares
//               the DUT against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_mem_arbiter;

  localparam int ADDR_W   = 24;
  localparam int FB_BASE  = 0;
  localparam int FB_WORDS = 60;
  localparam int DEPTH    = 4;
  localparam int LW       = 2;
  localparam int CPU_BASE = 32'h100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vid_frame = 1'b0;
  logic              vid_req = 1'b0;
  logic [31:0]       vid_data;
  logic              vid_underrun;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [3:0]        cpu_wstrb = '0;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = '0;
`ifdef VID_MEM_ARB_STATS_EN
  logic [15:0]       vid_underrun_cnt;
`endif

  always #5 clk = ~clk;

  vid_mem_arbiter #(
    .ADDR_W(ADDR_W), .FB_BASE(FB_BASE), .FB_WORDS(FB_WORDS),
    .FIFO_DEPTH(DEPTH), .LOW_WATER(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_frame(vid_frame), .vid_req(vid_req), .vid_data(vid_data), .vid_underrun(vid_underrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef VID_MEM_ARB_STATS_EN
    , .vid_underrun_cnt(vid_underrun_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs (percent, frame in per mille)
  int p_frame, p_vreq, p_cpu, p_ready, p_lat;
  bit first_cpu;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] last_pop;
  logic [31:0] cpu_mem [256];
  int          epoch, fcnt, ucnt_m, vid_cmds;
  bit          underrun_m, last_win_vid;
  bit          req_prev, cmd_vid;
  int          cmd_epoch;
  bit          rd_pending, rd_vid;
  int          rd_cnt, rd_epoch;
  logic [31:0] rd_data;
  bit          exp_ack, exp_ack_rd;
  logic [31:0] exp_rdata;
  bit          cpu_pending;
  bit          g_cpu, g_frame;
  int          g_q, g_fcnt;

  task automatic model_reset();
    q.delete();
    last_pop = '0;
    epoch = 0; fcnt = 0; ucnt_m = 0; vid_cmds = 0;
    underrun_m = 0; last_win_vid = 0;
    req_prev = 0; cmd_vid = 0; cmd_epoch = 0;
    rd_pending = 0; rd_vid = 0; rd_cnt = 0; rd_epoch = 0; rd_data = '0;
    exp_ack = 0; exp_ack_rd = 0; exp_rdata = '0;
    cpu_pending = 0;
    g_cpu = 0; g_frame = 0; g_q = 0; g_fcnt = 0;
    cpu_req = 0; vid_req = 0; vid_frame = 0; mem_ready = 0; mem_rvalid = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model over the next edge.
  task automatic cycle(input bit force_frame, input bit force_vreq);
    bit          frame_now, vreq_now, newcmd, is_vid, velig, exp_vid, push;
    int unsigned a_off;
    int          idx;
    @(negedge clk);

    chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
    if (exp_ack && exp_ack_rd) chk("cpu_rdata", cpu_rdata, exp_rdata);
    chk("vid_underrun", 32'(vid_underrun), 32'(underrun_m));
`ifdef VID_MEM_ARB_STATS_EN
    chk("underrun_cnt", 32'(vid_underrun_cnt), 32'(ucnt_m));
`endif
    if (exp_ack) cpu_pending = 0;

    newcmd = mem_req && !req_prev;
    if (newcmd) begin
      a_off   = 32'(mem_addr) - 32'(FB_BASE);
      is_vid  = !mem_we && (a_off < 32'(FB_WORDS));
      velig   = (g_q < DEPTH) && (g_fcnt < FB_WORDS) && !g_frame;
      exp_vid = velig && ((g_q < LW) || !g_cpu || !last_win_vid);
      chk("grant_is_video", 32'(is_vid), 32'(exp_vid));
      last_win_vid = is_vid;
      cmd_vid   = is_vid;
      cmd_epoch = epoch;
      if (is_vid) begin
        vid_cmds++;
        chk("vid_wstrb", 32'(mem_wstrb), 32'h0000000F);
      end else begin
        chk("cpu_cmd_pending", 32'(cpu_pending), 32'd1);
        chk("cpu_cmd_we", 32'(mem_we), 32'(cpu_we));
        chk("cpu_cmd_addr", 32'(mem_addr), 32'(cpu_addr));
        if (cpu_we) begin
          chk("cpu_cmd_wdata", mem_wdata, cpu_wdata);
          chk("cpu_cmd_wstrb", 32'(mem_wstrb), 32'(cpu_wstrb));
        end
      end
    end

    frame_now = force_frame || ($urandom_range(0, 999) < p_frame);
    vreq_now  = force_vreq || ($urandom_range(0, 99) < p_vreq);
    if (!cpu_pending && !exp_ack && ($urandom_range(0, 99) < p_cpu)) begin
      cpu_pending = 1;
      if (first_cpu) begin
        first_cpu = 0;
        cpu_we = 1'b1; cpu_addr = ADDR_W'(CPU_BASE);
        cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'b0011;
      end else begin
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = ADDR_W'(CPU_BASE + $urandom_range(0, 255));
        cpu_wdata = $urandom;
        cpu_wstrb = 4'($urandom_range(1, 15));
      end
    end
    cpu_req    = cpu_pending;
    vid_frame  = frame_now;
    vid_req    = vreq_now;
    mem_ready  = mem_req && ($urandom_range(0, 99) < p_ready);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (rd_pending) begin
      if (rd_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_data;
      end else begin
        rd_cnt--;
      end
    end

    if (vreq_now && !frame_now) begin
      if (q.size() > 0) chk("vid_data", vid_data, q[0]);
      else              chk("vid_data_hold", vid_data, last_pop);
    end

    // Advance the model across the coming clock edge.
    g_cpu = cpu_pending; g_q = q.size(); g_fcnt = fcnt; g_frame = frame_now;
    exp_ack = 0; exp_ack_rd = 0; push = 0;

    if (mem_rvalid) begin
      rd_pending = 0;
      if (rd_vid) push = !frame_now && (rd_epoch == epoch);
      else begin
        exp_ack = 1; exp_ack_rd = 1; exp_rdata = rd_data;
      end
    end

    if (mem_req && mem_ready) begin
      idx = int'(mem_addr) - CPU_BASE;
      if (cmd_vid) begin
        if (!frame_now && cmd_epoch == epoch) begin
          chk("fetch_addr", 32'(mem_addr), 32'(FB_BASE + fcnt));
          fcnt++;
        end
      end else if (mem_we) begin
        if (idx >= 0 && idx < 256) cpu_mem[idx] = merge(cpu_mem[idx], mem_wdata, mem_wstrb);
        exp_ack = 1;
      end
      if (!mem_we) begin
        rd_pending = 1;
        rd_cnt     = $urandom_range(0, p_lat);
        rd_vid     = cmd_vid;
        rd_epoch   = cmd_epoch;
        if (cmd_vid)                    rd_data = 32'(mem_addr);
        else if (idx >= 0 && idx < 256) rd_data = cpu_mem[idx];
        else                            rd_data = 32'hBAD0BAD0;
      end
    end

    if (frame_now) begin
      epoch++; fcnt = 0; q.delete(); underrun_m = 0; ucnt_m = 0; vid_cmds = 0;
    end else if (vreq_now) begin
      if (q.size() > 0) last_pop = q.pop_front();
      else begin
        underrun_m = 1;
        if (ucnt_m < 16'hFFFF) ucnt_m++;
      end
    end
    if (push) q.push_back(mem_rdata);
    req_prev = mem_req;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req), 32'd0);
    chk({tag, "_mem_we"},    32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    chk({tag, "_cpu_ack"},   32'(cpu_ack), 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_vid_data"},  vid_data, 32'd0);
    chk({tag, "_underrun"},  32'(vid_underrun), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) cpu_mem[i] = {8'hC0, 16'(i), 8'h5A};
    model_reset();
    first_cpu = 1;
    p_frame = 0; p_vreq = 0; p_cpu = 0; p_ready = 100; p_lat = 1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Frame start, no CPU, zero-wait memory: FIFO fills with words 0..3 then idles
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);
    chk("fill_video_cmds", 32'(vid_cmds), 32'd4);
    chk("fill_then_idle", 32'(mem_req), 32'd0);

    // One pop every 8 cycles, 16 pops: words 0..15 in order, no underrun
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1);
      for (int j = 0; j < 7; j++) cycle(1'b0, 1'b0);
    end

    // Mixed random traffic with variable memory latency and occasional frames
    p_cpu = 30; p_vreq = 20; p_ready = 60; p_lat = 3; p_frame = 3;
    for (int i = 0; i < 3000; i++) cycle(1'b0, 1'b0);

    // Heavy video demand to force underruns and frame exhaustion
    p_vreq = 70; p_cpu = 15; p_ready = 80; p_lat = 1;
    for (int i = 0; i < 800; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0);

    // Asynchronous reset in the middle of traffic
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p_vreq = 25; p_cpu = 30; p_ready = 70; p_lat = 2; p_frame = 4;
    for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vid_mem_arbiter.md
# vid_mem_arbiter

Shares the single 32-bit SDRAM command port between the video scan-out fetch path and the CPU data port. Keeps a small prefetch FIFO of framebuffer words so the video controller's per-2-pixel word request always finds data ready. Walks the framebuffer address linearly and restarts it at each frame. Sits between the video controller, the CPU bus and the SDRAM controller.

## Interface
- `ADDR_W`, 24: word-address width of the memory port.
- `FB_BASE`, 0: framebuffer base word address.
- `FB_WORDS`, 153600: 32-bit words per frame (640x480x16bpp / 2).
- `FIFO_DEPTH`, 4: prefetch FIFO entries (power of two, ≥2).
- `LOW_WATER`, 2: FIFO level below which video has absolute priority.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `vid_frame` in 1: one-cycle pulse at frame start (first line of vertical blank end).
- `vid_req` in 1: video word request; consumes one FIFO word.
- `vid_data` out 32: FIFO head word; valid in the cycle `vid_req` is high.
- `vid_underrun` out 1: sticky; a request found the FIFO empty; cleared by `vid_frame`.
- `cpu_req` in 1: CPU access request; held until `cpu_ack`.
- `cpu_we` in 1: 1 = write.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in 32: write data.
- `cpu_wstrb` in 4: byte enables.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: read data, valid with `cpu_ack`.
- `mem_req` out 1: command valid; held until `mem_ready`.
- `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out 32, `mem_wstrb` out 4: command fields, stable while `mem_req`.
- `mem_ready` in 1: command accepted this cycle.
- `mem_rvalid` in 1, `mem_rdata` in 32: read return, one beat per accepted read.

## Operation
- One memory transaction outstanding at most. FSM states:
  - IDLE: choose a grant, load the command, go to CMD.
  - CMD: hold `mem_req` until `mem_ready`. A write goes to DONE. A read goes to RD.
  - RD: wait for `mem_rvalid`, then return to IDLE.
  - DONE: pulse `cpu_ack` for the write, then return to IDLE.
- CPU reads pulse `cpu_ack` in the cycle after `mem_rvalid`. `cpu_rdata` is registered.
- Video fetch is eligible when the FIFO level is below `FIFO_DEPTH` and the frame is not exhausted (`fetch_cnt < FB_WORDS`).
- Grant in IDLE:
  - If video is eligible and the level is below `LOW_WATER`, video wins.
  - Otherwise, if both are eligible, grant alternates. The `last_grant` flag flips on each grant.
  - A sole requester always wins.
- Video reads use `mem_we=0`, `mem_wstrb=4'hF`, `mem_addr = FB_BASE + fetch_cnt`. `fetch_cnt` increments when the command is accepted (`mem_ready`).
- FIFO:
  - Push on `mem_rvalid` of a video read.
  - Pop on `vid_req` when not empty.
  - Simultaneous push and pop leave the level unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - The level counter is `$clog2(FIFO_DEPTH)+1` bits wide.
- `vid_req` with the FIFO empty: no pop, `vid_data` holds its last value, and `vid_underrun` is set.
- `vid_frame` has priority over everything:
  - Flushes the FIFO (level 0).
  - Sets `fetch_cnt` to 0 and clears `vid_underrun`.
  - A `vid_req` in the same cycle is ignored.
  - An in-flight video read completes on the bus, but its data is discarded via a `drop` flag.
  - An in-flight CPU transaction is unaffected.
- Once `fetch_cnt == FB_WORDS`, no further video fetches are issued until `vid_frame`.

## Timing
- Reset values:
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wstrb=0`.
  - `cpu_ack=0`, `cpu_rdata=0`.
  - `vid_data=0` (storage cleared), `vid_underrun=0`.
  - FIFO empty, `fetch_cnt=0`, FSM in IDLE, `last_grant`=CPU (video wins the first tie).
- `mem_req` rises 1 cycle after IDLE sees a grant. It falls in the cycle after `mem_ready` is sampled high.
- With a zero-wait memory (`mem_ready` immediate, `rvalid` 2 cycles later), a video fetch turnaround is 5 cycles.
- FIFO head to `vid_data` is combinational from storage. A pushed word is visible the cycle after `mem_rvalid`.
- Reset asserted mid-transaction aborts immediately; the memory side must also be reset.

## Configuration
- `VID_MEM_ARB_STATS_EN` defined: adds output `vid_underrun_cnt` [15:0].
  - Increments on every underrun request and saturates at 16'hFFFF.
  - Clears on `vid_frame` and on reset.
- Not defined: the port and counter are absent. `vid_underrun` still exists.

## Test plan
- Reset, then `vid_frame` with no CPU traffic → 4 reads at 0,1,2,3, FIFO full, `mem_req` then stays low.
- Pop 1 word every 8 cycles for 16 pops with memory data = address → `vid_data` 0..15 in order, `vid_underrun=0`.
- CPU writes `32'hDEADBEEF`, strb `4'b0011` to `0x100` while FIFO level=3 → grant alternates, `mem_wstrb=4'b0011`, one `cpu_ack` pulse.
- Hold FIFO at level 1 with CPU read pending → video granted first; CPU acked after the next video command.
- `vid_req` with FIFO empty, 3 times → `vid_underrun=1`, `vid_data` unchanged; with STATS_EN, count=3; `vid_frame` clears both.
- `vid_frame` during an in-flight video read at addr 57 → returned word dropped, next fetch address `FB_BASE`, FIFO refills from word 0.
